mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl.sv | 101 ++++++++++
 tb/tb_mem_stage_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller: sequences one data-memory access per instruction,
// stalls upstream while memory is busy, aborts on timeout and owns the MEM/WB register.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        MemToReg,
  input  logic [15:0] alu_result,
  input  logic [15:0] store_data,
  input  logic [3:0]  rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic        mem_err,
  output logic        wb_RegWrite,
  output logic        wb_MemToReg,
  output logic [15:0] wb_data,
  output logic [3:0]  wb_rd
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        access;
  logic        is_busy;
  logic        abort;
  logic        eff_mem_to_reg;
  logic        bubble;

  assign access    = MemRead | MemWrite;
  assign is_busy   = (state == BUSY);
  assign abort     = is_busy & (wait_cnt == TIMEOUT_C);
  assign mem_req   = (~is_busy & access) | is_busy;
  assign mem_we    = MemWrite;
  assign mem_addr  = alu_result;
  assign mem_wdata = store_data;
  assign stall     = mem_req & ~mem_ready & ~abort;

  // A simultaneous read+write is a store, so it never selects memory data for writeback.
  assign eff_mem_to_reg = MemToReg & ~(MemRead & MemWrite);

  // Completion wins over abort when mem_ready arrives on the timeout cycle.
  assign bubble = stall | (abort & ~mem_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      mem_err     <= 1'b0;
      wb_RegWrite <= 1'b0;
      wb_MemToReg <= 1'b0;
      wb_data     <= 16'd0;
      wb_rd       <= 4'd0;
    end else begin
      mem_err <= abort & ~mem_ready;

      case (state)
        IDLE: begin
          if (access && !mem_ready) begin
            state    <= BUSY;
            wait_cnt <= 8'd1;
          end
        end
        BUSY: begin
          if (mem_ready || abort) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= 8'd0;
        end
      endcase

      // A bubble only kills the write enable; the data fields keep their last value.
      if (bubble) begin
        wb_RegWrite <= 1'b0;
      end else begin
        wb_RegWrite <= RegWrite;
        wb_MemToReg <= eff_mem_to_reg;
        wb_data     <= eff_mem_to_reg ? mem_rdata : alu_result;
        wb_rd       <= rd;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: table of single-cycle vectors plus
// hand-written multi-cycle sequences, with MEM/WB expectations held in a scoreboard queue.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        MemRead, MemWrite, RegWrite, MemToReg;
  logic [15:0] alu_result, store_data, mem_rdata;
  logic [3:0]  rd;
  logic        mem_ready;
  logic        mem_req, mem_we, stall, mem_err;
  logic [15:0] mem_addr, mem_wdata, wb_data;
  logic        wb_RegWrite, wb_MemToReg;
  logic [3:0]  wb_rd;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        r, mr, mw, rw, m2r;
    logic [15:0] alu, sd;
    logic [3:0]  rdv;
    logic [15:0] rdata;
    logic        rdy;
    logic        e_req, e_we, e_stall;
    logic        e_rw, e_m2r;
    logic [15:0] e_data;
    logic [3:0]  e_rd;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic        rw, m2r;
    logic [15:0] data;
    logic [3:0]  rd;
    logic        err;
  } wb_exp_t;

  wb_exp_t sb_q[$];
  vec_t    table_v[7];

  mem_stage_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .alu_result(alu_result), .store_data(store_data), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall(stall), .mem_err(mem_err),
    .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg), .wb_data(wb_data), .wb_rd(wb_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic r, mr, mw, rw, m2r,
                              input logic [15:0] alu, sd, input logic [3:0] rdv,
                              input logic [15:0] rdata, input logic rdy,
                              input logic e_req, e_we, e_stall, e_rw, e_m2r,
                              input logic [15:0] e_data, input logic [3:0] e_rd,
                              input logic e_err);
    vec_t v;
    v.r = r; v.mr = mr; v.mw = mw; v.rw = rw; v.m2r = m2r;
    v.alu = alu; v.sd = sd; v.rdv = rdv; v.rdata = rdata; v.rdy = rdy;
    v.e_req = e_req; v.e_we = e_we; v.e_stall = e_stall;
    v.e_rw = e_rw; v.e_m2r = e_m2r; v.e_data = e_data; v.e_rd = e_rd; v.e_err = e_err;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst        = v.r;
    MemRead    = v.mr;
    MemWrite   = v.mw;
    RegWrite   = v.rw;
    MemToReg   = v.m2r;
    alu_result = v.alu;
    store_data = v.sd;
    rd         = v.rdv;
    mem_rdata  = v.rdata;
    mem_ready  = v.rdy;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp_v);
    end
  endtask

  // Called just after a rising edge: drive, check combinational outputs mid-cycle,
  // queue the MEM/WB expectation, then compare it after the next edge.
  task automatic run_cycle(input string tag, input vec_t v);
    wb_exp_t e;
    applyStimulus(v);
    @(negedge clk);
    checkOutput({tag, ".mem_req"},   16'(mem_req),   16'(v.e_req));
    checkOutput({tag, ".mem_we"},    16'(mem_we),    16'(v.e_we));
    checkOutput({tag, ".stall"},     16'(stall),     16'(v.e_stall));
    checkOutput({tag, ".mem_addr"},  mem_addr,       v.alu);
    checkOutput({tag, ".mem_wdata"}, mem_wdata,      v.sd);
    sb_q.push_back('{rw: v.e_rw, m2r: v.e_m2r, data: v.e_data, rd: v.e_rd, err: v.e_err});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL %s.scoreboard: got empty queue, expected one entry", tag);
    end else begin
      e = sb_q.pop_front();
      checkOutput({tag, ".wb_RegWrite"}, 16'(wb_RegWrite), 16'(e.rw));
      checkOutput({tag, ".wb_MemToReg"}, 16'(wb_MemToReg), 16'(e.m2r));
      checkOutput({tag, ".wb_data"},     wb_data,          e.data);
      checkOutput({tag, ".wb_rd"},       16'(wb_rd),       16'(e.rd));
      checkOutput({tag, ".mem_err"},     16'(mem_err),     16'(e.err));
    end
  endtask

  initial begin
    //                r  mr mw rw m2r alu       sd        rd     rdata     rdy req we st rw m2r data      rd     err
    table_v[0] = mk(0, 1, 0, 1, 1, 16'h0040, 16'h0000, 4'd3,  16'hBEEF, 1, 1, 0, 0, 1, 1, 16'hBEEF, 4'd3,  0);
    table_v[1] = mk(0, 0, 0, 1, 0, 16'h7FFF, 16'h0000, 4'd5,  16'h1111, 0, 0, 0, 0, 1, 0, 16'h7FFF, 4'd5,  0);
    table_v[2] = mk(0, 0, 1, 0, 0, 16'h0100, 16'hA5A5, 4'd2,  16'h0000, 1, 1, 1, 0, 0, 0, 16'h0100, 4'd2,  0);
    table_v[3] = mk(0, 1, 1, 1, 1, 16'h2222, 16'h3333, 4'd7,  16'h2222, 1, 1, 1, 0, 1, 0, 16'h2222, 4'd7,  0);
    table_v[4] = mk(0, 0, 0, 0, 0, 16'h0001, 16'h0000, 4'd1,  16'hFFFF, 1, 0, 0, 0, 0, 0, 16'h0001, 4'd1,  0);
    table_v[5] = mk(0, 1, 0, 1, 1, 16'hFFFF, 16'h0000, 4'd15, 16'h0000, 1, 1, 0, 0, 1, 1, 16'h0000, 4'd15, 0);
    table_v[6] = mk(0, 0, 0, 0, 0, 16'h8000, 16'h0000, 4'd0,  16'h0000, 0, 0, 0, 0, 0, 0, 16'h8000, 4'd0,  0);

    applyStimulus(mk(1, 0, 0, 0, 0, 16'h0, 16'h0, 4'd0, 16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 4'd0, 0));
    @(posedge clk);
    @(posedge clk);
    #1;
    run_cycle("reset", mk(1, 0, 0, 0, 0, 16'h0, 16'h0, 4'd0, 16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 4'd0, 0));

    for (int i = 0; i < 7; i++) run_cycle($sformatf("vec%0d", i), table_v[i]);

    // Three-wait store: stalls three cycles, completes on the fourth.
    for (int i = 0; i < 3; i++)
      run_cycle($sformatf("store3w.c%0d", i + 1),
                mk(0, 0, 1, 0, 0, 16'h1234, 16'h00FF, 4'd4, 16'h0, 0, 1, 1, 1, 0, 0, 16'h8000, 4'd0, 0));
    run_cycle("store3w.c4", mk(0, 0, 1, 0, 0, 16'h1234, 16'h00FF, 4'd4, 16'h0, 1, 1, 1, 0, 0, 0, 16'h1234, 4'd4, 0));

    // Timeout: fifteen stall cycles, then abort with one mem_err pulse and a bubble.
    for (int i = 0; i < 15; i++)
      run_cycle($sformatf("timeout.c%0d", i + 1),
                mk(0, 1, 0, 1, 1, 16'h0ABC, 16'h0, 4'd9, 16'hDEAD, 0, 1, 0, 1, 0, 0, 16'h1234, 4'd4, 0));
    run_cycle("timeout.abort", mk(0, 1, 0, 1, 1, 16'h0ABC, 16'h0, 4'd9, 16'hDEAD, 0, 1, 0, 0, 0, 0, 16'h1234, 4'd4, 1));
    run_cycle("timeout.after", mk(0, 0, 0, 0, 0, 16'h0000, 16'h0, 4'd0, 16'h0, 0, 0, 0, 0, 0, 0, 16'h0000, 4'd0, 0));

    // Reset on the second BUSY cycle abandons the load silently.
    run_cycle("rstbusy.alu", mk(0, 0, 0, 1, 0, 16'h3C3C, 16'h0, 4'd10, 16'h0, 0, 0, 0, 0, 1, 0, 16'h3C3C, 4'd10, 0));
    run_cycle("rstbusy.c1",  mk(0, 1, 0, 1, 1, 16'h0055, 16'h0, 4'd6, 16'h0, 0, 1, 0, 1, 0, 0, 16'h3C3C, 4'd10, 0));
    run_cycle("rstbusy.c2",  mk(0, 1, 0, 1, 1, 16'h0055, 16'h0, 4'd6, 16'h0, 0, 1, 0, 1, 0, 0, 16'h3C3C, 4'd10, 0));
    run_cycle("rstbusy.rst", mk(1, 1, 0, 1, 1, 16'h0055, 16'h0, 4'd6, 16'h0, 0, 1, 0, 1, 0, 0, 16'h0000, 4'd0, 0));
    run_cycle("rstbusy.idle", mk(0, 0, 0, 0, 0, 16'h0000, 16'h0, 4'd0, 16'h0, 0, 0, 0, 0, 0, 0, 16'h0000, 4'd0, 0));

    // Back-to-back one-wait loads.
    run_cycle("b2b.a1", mk(0, 1, 0, 1, 1, 16'h0010, 16'h0, 4'd1, 16'h0000, 0, 1, 0, 1, 0, 0, 16'h0000, 4'd0, 0));
    run_cycle("b2b.a2", mk(0, 1, 0, 1, 1, 16'h0010, 16'h0, 4'd1, 16'h1111, 1, 1, 0, 0, 1, 1, 16'h1111, 4'd1, 0));
    run_cycle("b2b.b1", mk(0, 1, 0, 1, 1, 16'h0020, 16'h0, 4'd2, 16'h0000, 0, 1, 0, 1, 0, 1, 16'h1111, 4'd1, 0));
    run_cycle("b2b.b2", mk(0, 1, 0, 1, 1, 16'h0020, 16'h0, 4'd2, 16'h2222, 1, 1, 0, 0, 1, 1, 16'h2222, 4'd2, 0));
    run_cycle("b2b.idle", mk(0, 0, 0, 0, 0, 16'h0000, 16'h0, 4'd0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 4'd0, 0));

    // mem_ready arriving on the timeout cycle counts as completion, not abort.
    for (int i = 0; i < 15; i++)
      run_cycle($sformatf("lastcycle.c%0d", i + 1),
                mk(0, 1, 0, 1, 1, 16'h0077, 16'h0, 4'd11, 16'h0000, 0, 1, 0, 1, 0, 0, 16'h0000, 4'd0, 0));
    run_cycle("lastcycle.done", mk(0, 1, 0, 1, 1, 16'h0077, 16'h0, 4'd11, 16'h600D, 1, 1, 0, 0, 1, 1, 16'h600D, 4'd11, 0));
    run_cycle("lastcycle.idle", mk(0, 0, 0, 0, 0, 16'h0000, 16'h0, 4'd0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 4'd0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
